cordic_arbiter: RTL and testbench

//  Shares the single iterative CORDIC (atan2/magnitude) among N_REQ requesters: roll, pitch and

---
 rtl/cordic_arbiter_pkg.sv | 21 ++
 rtl/cordic_arbiter_rr_pick.sv | 33 +++
 rtl/cordic_arbiter.sv | 155 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arbiter_pkg.sv
// Shared types and constants for the CORDIC arbiter: FSM state encoding,
// default operand width/watchdog depth and a ceil-log2 helper for sizing.
package cordic_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int CORDIC_W    = 16;
  localparam int DEF_TIMEOUT = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns a one-hot grant, its index and a valid flag.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          vld
);

  // One extra bit so ptr + offset can exceed N-1 before the single wrap.
  logic [PW:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = '0;
    for (int i = 0; i < N; i++) begin
      c = {1'b0, ptr} + (PW+1)'(i);
      if (c >= (PW+1)'(N)) c = c - (PW+1)'(N);
      if (!vld && req[c[PW-1:0]]) begin
        vld             = 1'b1;
        gnt[c[PW-1:0]]  = 1'b1;
        idx             = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one iterative CORDIC among N_REQ requesters:
// grant + operand capture, start sequencing, result routing and a done watchdog.
module cordic_arbiter
  import cordic_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = CORDIC_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   x_in,
  input  logic [N_REQ*WIDTH-1:0]   y_in,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]         rsp_angle,
  output logic [WIDTH-1:0]         rsp_mag,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     cordic_start,
  output logic [WIDTH-1:0]         cordic_x,
  output logic [WIDTH-1:0]         cordic_y,
  input  logic                     cordic_done,
  input  logic                     cordic_busy,
  input  logic [WIDTH-1:0]         cordic_angle,
  input  logic [WIDTH-1:0]         cordic_mag
);

  localparam int PW = clog2(N_REQ);
  localparam int TW = clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic [N_REQ-1:0] ack_q, ack_d, rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_angle_q, rsp_angle_d, rsp_mag_q, rsp_mag_d;
  logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
  logic             rsp_err_q, rsp_err_d, busy_q, busy_d, start_q, start_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic [WIDTH-1:0] x_arr [N_REQ];
  logic [WIDTH-1:0] y_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign x_arr[i] = x_in[i*WIDTH +: WIDTH];
    assign y_arr[i] = y_in[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_angle_d = rsp_angle_q;
    rsp_mag_d   = rsp_mag_q;
    start_d     = 1'b0;
    cx_d        = cx_q;
    cy_d        = cy_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          cx_d    = x_arr[pick_idx];
          cy_d    = y_arr[pick_idx];
          owner_d = pick_idx;
          ack_d   = pick_gnt;
          ptr_d   = (pick_idx == PW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!cordic_busy) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A done coinciding with watchdog expiry is still a good result.
        if (cordic_done) begin
          rsp_angle_d          = cordic_angle;
          rsp_mag_d            = cordic_mag;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end else if (wd_q == TW'(TIMEOUT-1)) begin
          rsp_angle_d          = '0;
          rsp_mag_d            = '0;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_angle_q <= '0;
      rsp_mag_q   <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_angle_q <= rsp_angle_d;
      rsp_mag_q   <= rsp_mag_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
    end
  end

  assign ack          = ack_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_angle    = rsp_angle_q;
  assign rsp_mag      = rsp_mag_q;
  assign busy         = busy_q;
  assign cordic_start = start_q;
  assign cordic_x     = cx_q;
  assign cordic_y     = cy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter; the CORDIC side is driven by hand from
// each scenario task, with expected values written out per test.
module tb_cordic_arbiter;

  localparam int N = 3;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] x_in, y_in;
  logic [N-1:0]   ack, rsp_valid;
  logic [W-1:0]   rsp_angle, rsp_mag, cordic_x, cordic_y, cordic_angle, cordic_mag;
  logic           rsp_err, busy, cordic_start, cordic_done, cordic_busy;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .x_in         (x_in),
    .y_in         (y_in),
    .ack          (ack),
    .rsp_valid    (rsp_valid),
    .rsp_angle    (rsp_angle),
    .rsp_mag      (rsp_mag),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .cordic_start (cordic_start),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_done  (cordic_done),
    .cordic_busy  (cordic_busy),
    .cordic_angle (cordic_angle),
    .cordic_mag   (cordic_mag)
  );

  // Outputs sampled and inputs changed 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; cordic_done = 1'b0; cordic_busy = 1'b0;
    cordic_angle = '0; cordic_mag = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; cordic_done = 1'b0; cordic_busy = 1'b0;
    x_in = '0; y_in = '0; cordic_angle = '0; cordic_mag = '0;
    repeat (2) tick();
    tot_cnt++;
    if ({ack, rsp_valid, rsp_err, busy, cordic_start} !== '0)
      $display("FAIL reset_ctrl got %b exp 0", {ack, rsp_valid, rsp_err, busy, cordic_start});
    else pass_cnt++;
    tot_cnt++;
    if ({rsp_angle, rsp_mag, cordic_x, cordic_y} !== '0)
      $display("FAIL reset_data got %h exp 0", {rsp_angle, rsp_mag, cordic_x, cordic_y});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    x_in = {16'h0, 16'h1000, 16'h0}; y_in = {16'h0, 16'h1000, 16'h0};
    req = 3'b010;
    tick();
    tot_cnt++;
    if (ack !== 3'b010) $display("FAIL t1_ack got %b exp 010", ack); else pass_cnt++;
    tot_cnt++;
    if (cordic_start !== 1'b0 || busy !== 1'b1)
      $display("FAIL t1_ack_cycle got start=%b busy=%b exp 0 1", cordic_start, busy);
    else pass_cnt++;
    req = '0;
    tick();
    tot_cnt++;
    if (cordic_start !== 1'b1 || ack !== 3'b000 || cordic_x !== 16'h1000 || cordic_y !== 16'h1000)
      $display("FAIL t1_start got start=%b ack=%b x=%h y=%h exp 1 000 1000 1000",
               cordic_start, ack, cordic_x, cordic_y);
    else pass_cnt++;
    repeat (9) tick();
    cordic_done = 1'b1; cordic_angle = 16'h2000; cordic_mag = 16'h16a1;
    tick();
    cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b010 || rsp_err !== 1'b0 || rsp_angle !== 16'h2000 || rsp_mag !== 16'h16a1)
      $display("FAIL t1_rsp got v=%b e=%b a=%h m=%h exp 010 0 2000 16a1",
               rsp_valid, rsp_err, rsp_angle, rsp_mag);
    else pass_cnt++;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL t1_idle_busy got %b exp 0", busy); else pass_cnt++;
    tick();
    tot_cnt++;
    if (rsp_valid !== 3'b000 || rsp_angle !== 16'h2000)
      $display("FAIL t1_hold got v=%b a=%h exp 000 2000", rsp_valid, rsp_angle);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_oh;
    logic [W-1:0] exp_x;
    apply_reset();
    x_in = {16'h3000, 16'h2000, 16'h1000}; y_in = {16'h0300, 16'h0200, 16'h0100};
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_oh = 3'b001 << (k % 3);
      exp_x  = 16'((k % 3 + 1) << 12);
      tick();
      tot_cnt++;
      if (ack !== exp_oh) $display("FAIL rr_ack%0d got %b exp %b", k, ack, exp_oh);
      else pass_cnt++;
      tick();
      tot_cnt++;
      if (cordic_x !== exp_x) $display("FAIL rr_x%0d got %h exp %h", k, cordic_x, exp_x);
      else pass_cnt++;
      cordic_done = 1'b1; cordic_angle = 16'h0100 + 16'(k); cordic_mag = 16'h0200 + 16'(k);
      tick();
      cordic_done = 1'b0;
      tot_cnt++;
      if (rsp_valid !== exp_oh || rsp_angle !== 16'h0100 + 16'(k) || rsp_mag !== 16'h0200 + 16'(k))
        $display("FAIL rr_rsp%0d got v=%b a=%h m=%h exp v=%b", k, rsp_valid, rsp_angle, rsp_mag, exp_oh);
      else pass_cnt++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_busy_stall();
    int early;
    apply_reset();
    x_in = {16'h0, 16'h0, 16'h0abc}; y_in = {16'h0, 16'h0, 16'h0def};
    cordic_busy = 1'b1;
    req = 3'b001;
    tick();
    tot_cnt++;
    if (ack !== 3'b001) $display("FAIL t3_ack got %b exp 001", ack); else pass_cnt++;
    req = '0; x_in = '1; y_in = '1;
    early = 0;
    repeat (5) begin
      tick();
      if (cordic_start) early++;
    end
    tot_cnt++;
    if (early != 0) $display("FAIL t3_stall got %0d early starts exp 0", early); else pass_cnt++;
    cordic_busy = 1'b0;
    tick();
    tot_cnt++;
    if (cordic_start !== 1'b1 || cordic_x !== 16'h0abc || cordic_y !== 16'h0def)
      $display("FAIL t3_start got s=%b x=%h y=%h exp 1 0abc 0def", cordic_start, cordic_x, cordic_y);
    else pass_cnt++;
    cordic_done = 1'b1; cordic_angle = 16'h0042; cordic_mag = 16'h0043;
    tick();
    cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b001 || rsp_err !== 1'b0)
      $display("FAIL t3_rsp got v=%b e=%b exp 001 0", rsp_valid, rsp_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    x_in = '0; y_in = '0;
    // Leave nonzero results behind so the forced zero on abort is visible.
    req = 3'b001;
    tick(); req = '0;
    tick();
    cordic_done = 1'b1; cordic_angle = 16'h1234; cordic_mag = 16'h5678;
    tick(); cordic_done = 1'b0;
    req = 3'b100;
    tick();
    tot_cnt++;
    if (ack !== 3'b100) $display("FAIL t4_ack got %b exp 100", ack); else pass_cnt++;
    req = '0;
    tick();
    n = 0;
    while (rsp_valid === 3'b000 && n < 200) begin
      tick();
      n++;
    end
    tot_cnt++;
    if (n != 64) $display("FAIL t4_latency got %0d exp 64", n); else pass_cnt++;
    tot_cnt++;
    if (rsp_valid !== 3'b100 || rsp_err !== 1'b1 || rsp_angle !== 16'h0 || rsp_mag !== 16'h0)
      $display("FAIL t4_abort got v=%b e=%b a=%h m=%h exp 100 1 0 0", rsp_valid, rsp_err, rsp_angle, rsp_mag);
    else pass_cnt++;
    req = 3'b010;
    tick(); req = '0;
    tick();
    cordic_done = 1'b1; cordic_angle = 16'h0aaa; cordic_mag = 16'h0bbb;
    tick(); cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b010 || rsp_err !== 1'b0 || rsp_angle !== 16'h0aaa)
      $display("FAIL t4_recover got v=%b e=%b a=%h exp 010 0 0aaa", rsp_valid, rsp_err, rsp_angle);
    else pass_cnt++;
  endtask

  task automatic test_stray_done();
    apply_reset();
    cordic_done = 1'b1; cordic_angle = 16'h5555; cordic_mag = 16'h6666;
    tick();
    cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0 || rsp_angle !== 16'h0)
      $display("FAIL t5_idle_done got v=%b b=%b a=%h exp 000 0 0", rsp_valid, busy, rsp_angle);
    else pass_cnt++;
    x_in = {16'h0, 16'h0, 16'h7777};
    req = 3'b001;
    tick(); req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if (busy !== 1'b0 || cordic_x !== 16'h0 || ack !== 3'b000)
      $display("FAIL t5_async_rst got b=%b x=%h ack=%b exp 0 0 000", busy, cordic_x, ack);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    cordic_done = 1'b1; cordic_angle = 16'h1111; cordic_mag = 16'h2222;
    tick();
    cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0 || rsp_angle !== 16'h0 || rsp_mag !== 16'h0)
      $display("FAIL t5_late_done got v=%b b=%b a=%h m=%h exp 000 0 0 0", rsp_valid, busy, rsp_angle, rsp_mag);
    else pass_cnt++;
  endtask

  task automatic test_done_at_expiry();
    int early;
    apply_reset();
    req = 3'b001;
    tick(); req = '0;
    tick();
    early = 0;
    repeat (63) begin
      tick();
      if (rsp_valid !== 3'b000) early++;
    end
    tot_cnt++;
    if (early != 0) $display("FAIL t6_early got %0d rsp exp 0", early); else pass_cnt++;
    cordic_done = 1'b1; cordic_angle = 16'h0777; cordic_mag = 16'h0888;
    tick();
    cordic_done = 1'b0;
    tot_cnt++;
    if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_angle !== 16'h0777 || rsp_mag !== 16'h0888)
      $display("FAIL t6_race got v=%b e=%b a=%h m=%h exp 001 0 0777 0888", rsp_valid, rsp_err, rsp_angle, rsp_mag);
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_stall();
    test_timeout();
    test_stray_done();
    test_done_at_expiry();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
